relm_uart_tx_io: RTL and testbench

Serial transmitter peripheral that sits on a ReLM PE push channel as its responder and on a pop channel as a status/flush port. It accepts words from `PUSH/OUT`, buffers them in an internal FIFO, and shifts each character out on `txd` as 8N1-style asynchronous serial. It also executes in-order divisor-change commands. It is the transmit-side counterpart of a receiver feeding a pop channel.

---
 rtl/relm_uart_tx_io_if.sv | 13 +
 rtl/relm_uart_tx_io.sv | 137 +++++++++++++
 tb/tb_relm_uart_tx_io.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/relm_uart_tx_io_if.sv
// ReLM PE channel bundle for the UART transmitter.
// Carries the push data channel and the pop status/flush channel.
interface relm_uart_tx_io_if #(
  parameter int WD = 32
);
  logic [WD:0] push_d;
  logic        push_retry;
  logic [WD:0] pop_d;
  logic [WD:0] pop_q;

  modport master (output push_d, output pop_d, input push_retry, input pop_q);
  modport slave  (input push_d, input pop_d, output push_retry, output pop_q);
endinterface

// File: rtl/relm_uart_tx_io.sv
// FIFO-buffered 8N1-style serial transmitter on a ReLM push channel.
// Also handles in-order divisor commands and a pop-side status/flush port.
module relm_uart_tx_io #(
  parameter int WD    = 32,
  parameter int WAD   = 4,
  parameter int WCHAR = 8,
  parameter int WBAUD = 16,
  parameter int DIV   = 868
) (
  input  logic             clk,
  input  logic             rst,
  relm_uart_tx_io_if.slave bus,
  output logic             txd
);
  localparam int WP    = (WCHAR > WBAUD) ? WCHAR : WBAUD;
  localparam int WBC   = $clog2(WCHAR + 1);
  localparam int DEPTH = 2 ** WAD;

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [WP:0]      mem [DEPTH];
  logic [WP:0]      rd_data;
  logic [WAD:0]     wr_ptr, rd_ptr, occ;
  logic             empty, full, accept, deq, flush, busy, retry;
  logic             baud_zero, last_bit, is_cmd;
  logic [WBAUD-1:0] div, baudcnt, cmd_div;
  logic [WCHAR-1:0] shreg;
  logic [WBC-1:0]   bitcnt;
  logic [WD-1:0]    status;
  logic             unused_bits;

  assign empty     = (rd_ptr == wr_ptr);
  assign full      = (rd_ptr[WAD-1:0] == wr_ptr[WAD-1:0]) && (rd_ptr[WAD] != wr_ptr[WAD]);
  assign occ       = wr_ptr - rd_ptr;
  assign retry     = full & ~deq;
  assign accept    = bus.push_d[WD] & ~retry;
  assign flush     = bus.pop_d[WD] & bus.pop_d[0];
  assign busy      = (state != IDLE) | ~empty;
  assign baud_zero = (baudcnt == '0);
  assign last_bit  = (bitcnt == WBC'(WCHAR - 1));
  assign is_cmd    = rd_data[WP];
  assign cmd_div   = rd_data[WBAUD-1:0];

  // Payload bits above the stored width and the unused pop bits are dropped.
  assign unused_bits = ^{bus.pop_d[WD-1:1], bus.push_d[WD-2:WP]};

  assign bus.push_retry = retry;
  assign bus.pop_q      = {1'b0, status};

  always_comb begin
    status          = '0;
    status[WAD:0]   = occ;
    status[WAD+1]   = busy;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[WAD-1:0]] <= {bus.push_d[WD-1], bus.push_d[WP-1:0]};
  end

  // A flush that coincides with an accept must also skip the word being written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + (WAD+1)'(1);
      if (flush) rd_ptr <= wr_ptr + (WAD+1)'(accept);
      else if (deq) rd_ptr <= rd_ptr + (WAD+1)'(1);
      if (deq) rd_data <= mem[rd_ptr[WAD-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = FETCH;
      FETCH:   state_next = is_cmd ? IDLE : START;
      START:   if (baud_zero) state_next = DATA;
      DATA:    if (baud_zero && last_bit) state_next = STOP;
      STOP:    if (baud_zero) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    deq = 1'b0;
    txd = 1'b1;
    case (state)
      IDLE:    deq = ~empty;
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
      default: ;
    endcase
  end

  // Every timed state reloads div-1 on entry and advances when the count reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= WBAUD'(DIV);
      baudcnt <= '0;
      shreg   <= '0;
      bitcnt  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (is_cmd) begin
            div <= (cmd_div == '0) ? WBAUD'(1) : cmd_div;
          end else begin
            shreg   <= rd_data[WCHAR-1:0];
            bitcnt  <= '0;
            baudcnt <= div - WBAUD'(1);
          end
        end
        START, STOP: begin
          baudcnt <= baud_zero ? div - WBAUD'(1) : baudcnt - WBAUD'(1);
        end
        DATA: begin
          if (baud_zero) begin
            baudcnt <= div - WBAUD'(1);
            shreg   <= shreg >> 1;
            bitcnt  <= bitcnt + WBC'(1);
          end else begin
            baudcnt <= baudcnt - WBAUD'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_relm_uart_tx_io.sv
// Scoreboard bench for relm_uart_tx_io: pushes queue expected frames,
// a line monitor decodes txd and checks each frame's bits and bit timing.
module tb_relm_uart_tx_io;
  localparam int WD    = 32;
  localparam int WAD   = 2;
  localparam int WCHAR = 8;
  localparam int WBAUD = 16;
  localparam int DIV   = 4;

  typedef struct {
    logic [7:0] ch;
    int         div;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic txd;

  relm_uart_tx_io_if #(.WD(WD)) bus ();

  relm_uart_tx_io #(
    .WD(WD), .WAD(WAD), .WCHAR(WCHAR), .WBAUD(WBAUD), .DIV(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .txd(txd)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   model_div = DIV;
  int   frame_no  = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic apply_stimulus(input logic cmd, input logic [30:0] payload,
                                output int waits, output logic [WD:0] acc_status);
    waits = 0;
    bus.push_d = {1'b1, cmd, payload};
    @(negedge clk);
    while (bus.push_retry && waits < 2000) begin
      waits++;
      @(negedge clk);
    end
    acc_status = bus.pop_q;
    if (bus.push_retry) begin
      check_output("push_accept_timeout", {63'd0, bus.push_retry}, 64'd0);
      bus.push_d = '0;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      bus.push_d = '0;
      if (cmd) model_div = (payload[15:0] == 16'd0) ? 1 : int'(payload[15:0]);
      else exp_q.push_back('{payload[7:0], model_div});
    end
  endtask

  task automatic flush_pulse();
    bus.pop_d = {1'b1, {(WD-1){1'b0}}, 1'b1};
    @(posedge clk);
    #1;
    bus.pop_d = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.pop_q[WAD+1] && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check_output({name, "_idle_status"}, 64'(bus.pop_q), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Line monitor: each start bit pops one expected frame and samples every clock of it.
  initial begin : monitor
    logic       prev;
    logic       aborted;
    logic       lvl;
    logic [7:0] rx;
    int         bad;
    exp_t       e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else begin
        if (prev && !txd) begin
          check_output("start_expected", {63'd0, exp_q.size() != 0}, 64'd1);
          if (exp_q.size() != 0) begin
            e       = exp_q.pop_front();
            rx      = '0;
            bad     = 0;
            aborted = 1'b0;
            for (int b = 0; b < WCHAR + 2 && !aborted; b++) begin
              if (b == 0) lvl = 1'b0;
              else if (b == WCHAR + 1) lvl = 1'b1;
              else lvl = e.ch[b-1];
              for (int s = 0; s < e.div && !aborted; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                if (rst) begin
                  aborted = 1'b1;
                end else begin
                  if (s == 0 && b >= 1 && b <= WCHAR) rx[b-1] = txd;
                  if (txd !== lvl) bad++;
                end
              end
            end
            if (!aborted) begin
              check_output($sformatf("frame%0d_char", frame_no), 64'(rx), 64'(e.ch));
              check_output($sformatf("frame%0d_timing", frame_no), 64'(bad), 64'd0);
              frame_no++;
            end
          end
        end
        prev = rst ? 1'b1 : txd;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int          waits;
    logic [WD:0] st;
    logic [7:0]  ch;

    bus.push_d = '0;
    bus.pop_d  = '0;
    rst        = 1'b1;
    #3;
    check_output("reset_txd", {63'd0, txd}, 64'd1);
    check_output("reset_retry", {63'd0, bus.push_retry}, 64'd0);
    check_output("reset_status", 64'(bus.pop_q), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single character, start-bit latency and busy clearing.
    apply_stimulus(1'b0, 31'h55, waits, st);
    @(negedge clk);
    check_output("t1_status_accept", 64'(bus.pop_q), 64'h9);
    @(negedge clk);
    check_output("t1_txd_fetch", {63'd0, txd}, 64'd1);
    @(negedge clk);
    check_output("t1_start_latency", {63'd0, txd}, 64'd0);
    @(posedge clk);
    #1;
    wait_idle("t1");

    // Fill the 4-entry FIFO behind a running frame.
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 31'(8'hA1 + i), waits, st);
    @(negedge clk);
    check_output("t2_retry_full", {63'd0, bus.push_retry}, 64'd1);
    check_output("t2_status_full", 64'(bus.pop_q), 64'hC);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 31'hA6, waits, st);
    check_output("t2_retry_seen", {63'd0, waits > 0}, 64'd1);
    check_output("t2_status_at_deq", 64'(st), 64'hC);
    @(negedge clk);
    check_output("t2_status_after_accept", 64'(bus.pop_q), 64'hC);
    @(posedge clk);
    #1;
    wait_idle("t2");

    // Divisor commands take effect in FIFO order; 0 clamps to 1, high payload bits ignored.
    apply_stimulus(1'b0, 31'h41, waits, st);
    apply_stimulus(1'b1, 31'h2, waits, st);
    apply_stimulus(1'b0, 31'h42, waits, st);
    apply_stimulus(1'b1, 31'h0, waits, st);
    apply_stimulus(1'b0, 31'h43, waits, st);
    apply_stimulus(1'b1, 31'h10003, waits, st);
    apply_stimulus(1'b0, 31'h44, waits, st);
    apply_stimulus(1'b1, 31'h4, waits, st);
    wait_idle("t3");

    // Flush during the first frame's data bits; queued characters are dropped.
    apply_stimulus(1'b0, 31'h61, waits, st);
    apply_stimulus(1'b0, 31'h62, waits, st);
    apply_stimulus(1'b0, 31'h63, waits, st);
    repeat (8) @(posedge clk);
    #1;
    flush_pulse();
    exp_q.delete();
    @(negedge clk);
    check_output("t4_status_after_flush", 64'(bus.pop_q), 64'h8);
    @(posedge clk);
    #1;
    wait_idle("t4");
    repeat (30) @(posedge clk);
    #1;

    // Flush together with an accepted push discards that word.
    bus.push_d = {1'b1, 1'b0, 31'h77};
    bus.pop_d  = {1'b1, {(WD-1){1'b0}}, 1'b1};
    @(posedge clk);
    #1;
    bus.push_d = '0;
    bus.pop_d  = '0;
    @(negedge clk);
    check_output("t4_flush_push_status", 64'(bus.pop_q), 64'h0);
    repeat (20) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a zero-data frame at divisor 6.
    apply_stimulus(1'b1, 31'h6, waits, st);
    apply_stimulus(1'b0, 31'h00, waits, st);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_output("t5_txd_before_reset", {63'd0, txd}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check_output("t5_txd_async", {63'd0, txd}, 64'd1);
    check_output("t5_status_async", 64'(bus.pop_q), 64'd0);
    check_output("t5_retry_async", {63'd0, bus.push_retry}, 64'd0);
    exp_q.delete();
    model_div = DIV;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 31'h3C, waits, st);
    wait_idle("t5");

    // Twenty characters through the 4-entry FIFO exercise pointer wrap-around.
    for (int i = 0; i < 20; i++) begin
      ch = 8'(i * 37 + 5);
      apply_stimulus(1'b0, {23'd0, ch}, waits, st);
    end
    wait_idle("t6");
    check_output("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
